// File: rtl/sevenseg_scan_decoder.sv
// Receive-side decoder for a multiplexed seven-segment display: rebuilds the four
// BCD digits from the Anode/Cathode scan lines and flags blanked slots and bad patterns.
module sevenseg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES  = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] Anode,
   input  logic [6:0] Cathode,
   output logic [3:0] min_ten,
   output logic [3:0] min_one,
   output logic [3:0] sec_ten,
   output logic [3:0] sec_one,
   output logic [3:0] blank_mask,
   output logic       frame_valid,
   output logic       seg_err,
   output logic       anode_err
);

   localparam int unsigned PAT_W    = 11;
   localparam int unsigned SLOTS    = 4;
   localparam int unsigned SCNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TCNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STABLE_CYCLES);
   localparam logic [SCNT_W-1:0] SCNT_FIRE = SCNT_W'(STABLE_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic {SETTLE, HELD} state_t;

   // Returns {legal, digit} for an active-low {g,f,e,d,c,b,a} pattern.
   function automatic logic [4:0] seg_decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'b1000000: r = {1'b1, 4'd0};
         7'b1111001: r = {1'b1, 4'd1};
         7'b0100100: r = {1'b1, 4'd2};
         7'b0110000: r = {1'b1, 4'd3};
         7'b0011001: r = {1'b1, 4'd4};
         7'b0010010: r = {1'b1, 4'd5};
         7'b0000010: r = {1'b1, 4'd6};
         7'b1111000: r = {1'b1, 4'd7};
         7'b0000000: r = {1'b1, 4'd8};
         7'b0010000: r = {1'b1, 4'd9};
         default:    r = 5'd0;
      endcase
      return r;
   endfunction

   logic [PAT_W-1:0]  sync1, sync2, prev_pat, cap_pat;
   logic              changed;
   state_t            state, state_nxt;
   logic [SCNT_W-1:0] stable_cnt, stable_cnt_nxt;
   logic              capture_c, capture;

   // Two-flop synchronizer; reset value is a dark display.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {Anode, Cathode};
         sync2 <= sync1;
      end
   end

   assign changed = (sync2 != prev_pat);

   // Stability filter state register plus the registered capture event.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= SETTLE;
         stable_cnt <= '0;
         prev_pat   <= '1;
         capture    <= 1'b0;
         cap_pat    <= '1;
      end else begin
         state      <= state_nxt;
         stable_cnt <= stable_cnt_nxt;
         prev_pat   <= sync2;
         capture    <= capture_c;
         if (capture_c) cap_pat <= sync2;
      end
   end

   always_comb begin
      state_nxt      = state;
      stable_cnt_nxt = stable_cnt;
      capture_c      = 1'b0;
      if (changed) begin
         state_nxt      = SETTLE;
         stable_cnt_nxt = '0;
      end else begin
         if (stable_cnt != SCNT_MAX) stable_cnt_nxt = stable_cnt + SCNT_W'(1);
         if (state == SETTLE && stable_cnt == SCNT_FIRE) begin
            capture_c = 1'b1;
            state_nxt = HELD;
         end
      end
   end

   logic [3:0]        cap_an;
   logic [6:0]        cap_seg;
   logic [4:0]        dec;
   logic [3:0]        seen, seen_nxt;
   logic [3:0]        shadow     [SLOTS];
   logic [3:0]        shadow_nxt [SLOTS];
   logic [3:0]        digit_q    [SLOTS];
   logic [TCNT_W-1:0] tcnt;
   logic              seg_err_c, anode_err_c, complete_c, timeout_c, emit_c;

   assign cap_an  = cap_pat[10:7];
   assign cap_seg = cap_pat[6:0];

   // Classify the captured pattern and decide on frame emission.
   always_comb begin
      seen_nxt    = seen;
      shadow_nxt  = shadow;
      seg_err_c   = 1'b0;
      anode_err_c = 1'b0;
      dec         = seg_decode(cap_seg);
      if (capture && cap_an != 4'b1111) begin
         if ($countones(~cap_an) == 1) begin
            if (dec[4]) begin
               for (int i = 0; i < int'(SLOTS); i++) begin
                  if (!cap_an[i]) begin
                     shadow_nxt[i] = dec[3:0];
                     seen_nxt[i]   = 1'b1;
                  end
               end
            end else begin
               seg_err_c = 1'b1;
            end
         end else begin
            anode_err_c = 1'b1;
         end
      end
      complete_c = (seen_nxt == 4'b1111);
      timeout_c  = (tcnt == TCNT_LAST);
      emit_c     = complete_c | timeout_c;
   end

   // Shadow digits, frame tracking and registered outputs; completion wins over timeout.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         seen        <= '0;
         tcnt        <= '0;
         blank_mask  <= '0;
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         anode_err   <= 1'b0;
         for (int i = 0; i < int'(SLOTS); i++) begin
            shadow[i]  <= '0;
            digit_q[i] <= '0;
         end
      end else begin
         seg_err     <= seg_err_c;
         anode_err   <= anode_err_c;
         frame_valid <= emit_c;
         shadow      <= shadow_nxt;
         if (emit_c) begin
            seen       <= '0;
            tcnt       <= '0;
            blank_mask <= complete_c ? 4'b0000 : ~seen_nxt;
            for (int i = 0; i < int'(SLOTS); i++) begin
               if (seen_nxt[i]) digit_q[i] <= shadow_nxt[i];
            end
         end else begin
            seen <= seen_nxt;
            tcnt <= tcnt + TCNT_W'(1);
         end
      end
   end

   assign min_ten = digit_q[3];
   assign min_one = digit_q[2];
   assign sec_ten = digit_q[1];
   assign sec_one = digit_q[0];

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scenarios plus random scans, checked against
// a run-length/event-queue reference model of the scan decoding rules.
`timescale 1ns/1ps
module tb_sevenseg_scan_decoder;

   localparam int unsigned S = 8;
   localparam int unsigned T = 200;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] an;
   logic [6:0] ca;
   logic [3:0] min_ten, min_one, sec_ten, sec_one, blank_mask;
   logic       frame_valid, seg_err, anode_err;

   sevenseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .Anode(an), .Cathode(ca),
      .min_ten(min_ten), .min_one(min_one), .sec_ten(sec_ten), .sec_one(sec_one),
      .blank_mask(blank_mask), .frame_valid(frame_valid),
      .seg_err(seg_err), .anode_err(anode_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         default: return 7'b0010000;
      endcase
   endfunction

   function automatic logic [3:0] slot_an(input int s);
      return 4'(~(4'b0001 << s));
   endfunction

   // ---------------- reference model ----------------
   // A run of identical input samples spanning S+1 edges is processed 3 edges later.
   typedef struct { int at; logic [10:0] pat; } pend_t;
   pend_t       pend_q[$];
   pend_t       m_p;
   int          edge_n = 0, run_start = 0, since = 0, m_low, m_slot, m_d;
   bit          cap_done = 1;
   logic [10:0] last_in = '1;
   logic [3:0]  m_an;
   logic [6:0]  m_ca;
   logic [3:0]  m_shadow [4];
   logic [3:0]  m_dig [4];
   logic [3:0]  m_seen = '0, m_mask = '0;
   logic        m_fv = 0, m_se = 0, m_ae = 0;

   always @(posedge clk) begin
      if (!reset_n) begin
         pend_q.delete();
         last_in = '1; cap_done = 1; since = 0;
         m_seen = '0; m_mask = '0; m_fv = 0; m_se = 0; m_ae = 0;
         for (int i = 0; i < 4; i++) begin m_shadow[i] = '0; m_dig[i] = '0; end
      end else begin
         edge_n++;
         if ({an, ca} != last_in) begin
            last_in = {an, ca}; run_start = edge_n; cap_done = 0;
         end
         if (!cap_done && (edge_n - run_start) == int'(S)) begin
            m_p.at = edge_n + 3; m_p.pat = last_in;
            pend_q.push_back(m_p);
            cap_done = 1;
         end
         m_fv = 0; m_se = 0; m_ae = 0;
         if (pend_q.size() > 0 && pend_q[0].at == edge_n) begin
            m_p = pend_q.pop_front();
            m_an = m_p.pat[10:7]; m_ca = m_p.pat[6:0];
            m_low = 0; m_slot = 0;
            for (int i = 0; i < 4; i++) if (!m_an[i]) begin m_low++; m_slot = i; end
            if (m_low == 1) begin
               m_d = -1;
               for (int d = 0; d < 10; d++) if (seg_of(d) == m_ca) m_d = d;
               if (m_d < 0) m_se = 1;
               else begin m_shadow[m_slot] = 4'(m_d); m_seen[m_slot] = 1'b1; end
            end else if (m_low > 1) begin
               m_ae = 1;
            end
         end
         since++;
         if (m_seen == 4'hf || since == int'(T)) begin
            for (int i = 0; i < 4; i++) if (m_seen[i]) m_dig[i] = m_shadow[i];
            m_mask = ~m_seen; m_seen = '0; since = 0; m_fv = 1;
         end
      end
   end

   // ---------------- observation ----------------
   bit          chk_en = 0;
   int          mism_cnt = 0, dbl_cnt = 0;
   int          dut_fv = 0, dut_se = 0, dut_ae = 0, mdl_fv = 0, mdl_se = 0, mdl_ae = 0;
   logic [22:0] dut_vec, mdl_vec, bad_dut, bad_mdl;
   logic [19:0] last_frame = '0;
   logic        prev_fv = 0, prev_se = 0, prev_ae = 0;

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         dut_vec = {frame_valid, seg_err, anode_err, blank_mask, min_ten, min_one, sec_ten, sec_one};
         mdl_vec = {m_fv, m_se, m_ae, m_mask, m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
         if (dut_vec !== mdl_vec) begin mism_cnt++; bad_dut = dut_vec; bad_mdl = mdl_vec; end
         if (frame_valid === 1'b1) begin
            dut_fv++;
            last_frame = {blank_mask, min_ten, min_one, sec_ten, sec_one};
         end
         if (seg_err === 1'b1) dut_se++;
         if (anode_err === 1'b1) dut_ae++;
         if (m_fv) mdl_fv++;
         if (m_se) mdl_se++;
         if (m_ae) mdl_ae++;
         if ((frame_valid && prev_fv) || (seg_err && prev_se) || (anode_err && prev_ae)) dbl_cnt++;
         prev_fv = frame_valid; prev_se = seg_err; prev_ae = anode_err;
      end
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic hold(input logic [3:0] a, input logic [6:0] c, input int n);
      an = a; ca = c;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 0; an = 4'hf; ca = 7'h7f;
      repeat (2) @(negedge clk);
      reset_n = 1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int fv0, se0, ae0;
      reset_n = 0; an = 4'hf; ca = 7'h7f;
      repeat (3) @(negedge clk);
      chk_en = 1;
      checks++;
      if ({frame_valid, seg_err, anode_err, blank_mask, min_ten, min_one, sec_ten, sec_one} !== 23'd0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 0",
                  {frame_valid, seg_err, anode_err, blank_mask, min_ten, min_one, sec_ten, sec_one});
      end
      reset_n = 1;
      fv0 = dut_fv; se0 = dut_se; ae0 = dut_ae;
      hold(4'hf, 7'h7f, 30);
      checks++;
      if ((dut_fv - fv0) + (dut_se - se0) + (dut_ae - ae0) !== 0) begin
         errors++;
         $display("FAIL idle_no_pulses got %0d expected 0", (dut_fv - fv0) + (dut_se - se0) + (dut_ae - ae0));
      end
   endtask

   task automatic test_clean_scan();
      int fv0, mm0;
      fv0 = dut_fv; mm0 = mism_cnt;
      for (int r = 0; r < 3; r++) begin
         hold(slot_an(1), seg_of(3), 20);
         hold(slot_an(2), seg_of(2), 20);
         hold(slot_an(3), seg_of(1), 20);
         hold(slot_an(0), seg_of(4), 20);
      end
      checks++;
      if (dut_fv - fv0 !== 3) begin errors++; $display("FAIL clean_frames got %0d expected 3", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'h01234) begin errors++; $display("FAIL clean_digits got %h expected 01234", last_frame); end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL clean_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
   endtask

   task automatic test_blink();
      int fv0, mm0;
      fv0 = dut_fv; mm0 = mism_cnt;
      for (int r = 0; r < 4; r++) begin
         hold(slot_an(3), seg_of(0), 20);
         hold(slot_an(2), seg_of(5), 20);
         hold(4'hf, 7'h7f, 40);
      end
      checks++;
      if (dut_fv - fv0 !== 1) begin errors++; $display("FAIL blink_frames got %0d expected 1", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'h30534) begin errors++; $display("FAIL blink_frame got %h expected 30534", last_frame); end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL blink_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
   endtask

   task automatic test_glitch();
      int fv0, se0, ae0, mm0;
      do_reset();
      fv0 = dut_fv; se0 = dut_se; ae0 = dut_ae; mm0 = mism_cnt;
      hold(4'hf, 7'h7f, 5);
      hold(slot_an(0), seg_of(7), 20);
      hold(slot_an(0), 7'b0000000, int'(S) - 1);
      hold(slot_an(0), seg_of(7), 20);
      hold(slot_an(3), seg_of(1), 20);
      hold(slot_an(2), seg_of(2), 20);
      hold(slot_an(1), seg_of(3), 20);
      checks++;
      if (dut_fv - fv0 !== 1) begin errors++; $display("FAIL glitch_frames got %0d expected 1", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'h01237) begin errors++; $display("FAIL glitch_frame got %h expected 01237", last_frame); end
      checks++;
      if ((dut_se - se0) + (dut_ae - ae0) !== 0) begin
         errors++; $display("FAIL glitch_errors got %0d expected 0", (dut_se - se0) + (dut_ae - ae0));
      end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL glitch_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
   endtask

   task automatic test_illegal();
      int fv0, se0, ae0, mm0;
      do_reset();
      fv0 = dut_fv; se0 = dut_se; ae0 = dut_ae; mm0 = mism_cnt;
      hold(4'hf, 7'h7f, 5);
      hold(4'b1110, 7'b1111111, 20);
      hold(4'b1100, seg_of(5), 20);
      hold(slot_an(3), seg_of(4), 20);
      hold(slot_an(2), seg_of(5), 20);
      hold(slot_an(1), seg_of(6), 20);
      checks++;
      if (dut_se - se0 !== 1) begin errors++; $display("FAIL seg_err_pulses got %0d expected 1", dut_se - se0); end
      checks++;
      if (dut_ae - ae0 !== 1) begin errors++; $display("FAIL anode_err_pulses got %0d expected 1", dut_ae - ae0); end
      checks++;
      if (dut_fv - fv0 !== 0) begin errors++; $display("FAIL illegal_no_seen got %0d frames expected 0", dut_fv - fv0); end
      hold(slot_an(0), seg_of(9), 20);
      checks++;
      if (dut_fv - fv0 !== 1) begin errors++; $display("FAIL illegal_complete got %0d frames expected 1", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'h04569) begin errors++; $display("FAIL illegal_frame got %h expected 04569", last_frame); end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL illegal_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
   endtask

   task automatic test_simultaneous();
      int fv0, mm0;
      do_reset();
      fv0 = dut_fv; mm0 = mism_cnt;
      hold(4'hf, 7'h7f, 5);
      hold(slot_an(3), seg_of(1), 20);
      hold(slot_an(2), seg_of(2), 20);
      hold(slot_an(1), seg_of(3), 20);
      an = 4'hf; ca = 7'h7f;
      for (int w = 0; w < 400 && since != int'(T - S - 4); w++) @(negedge clk);
      checks++;
      if (since !== int'(T - S - 4)) begin
         errors++; $display("FAIL sim_align got %0d expected %0d", since, T - S - 4);
      end
      hold(slot_an(0), seg_of(4), 20);
      checks++;
      if (dut_fv - fv0 !== 1) begin errors++; $display("FAIL sim_frames got %0d expected 1", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'h01234) begin errors++; $display("FAIL sim_frame got %h expected 01234", last_frame); end
      hold(4'hf, 7'h7f, int'(T) + 5);
      checks++;
      if (dut_fv - fv0 !== 2) begin errors++; $display("FAIL dark_frames got %0d expected 2", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'hF1234) begin errors++; $display("FAIL dark_frame got %h expected f1234", last_frame); end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL sim_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
   endtask

   task automatic test_reset_midframe();
      int fv0, mm0;
      do_reset();
      mm0 = mism_cnt;
      hold(4'hf, 7'h7f, 5);
      hold(slot_an(3), seg_of(9), 20);
      hold(slot_an(2), seg_of(8), 20);
      hold(slot_an(1), seg_of(7), 20);
      hold(slot_an(0), seg_of(6), 20);
      checks++;
      if (last_frame !== 20'h09876) begin errors++; $display("FAIL pre_reset_frame got %h expected 09876", last_frame); end
      hold(slot_an(3), seg_of(1), 20);
      hold(slot_an(2), seg_of(2), 20);
      do_reset();
      checks++;
      if ({frame_valid, blank_mask, min_ten, min_one, sec_ten, sec_one} !== 21'd0) begin
         errors++;
         $display("FAIL midreset_outputs got %h expected 0", {frame_valid, blank_mask, min_ten, min_one, sec_ten, sec_one});
      end
      fv0 = dut_fv;
      hold(4'hf, 7'h7f, 5);
      hold(slot_an(1), seg_of(5), 20);
      hold(slot_an(0), seg_of(5), 20);
      checks++;
      if (dut_fv - fv0 !== 0) begin errors++; $display("FAIL midreset_partial got %0d frames expected 0", dut_fv - fv0); end
      hold(slot_an(3), seg_of(1), 20);
      hold(slot_an(2), seg_of(2), 20);
      checks++;
      if (dut_fv - fv0 !== 1) begin errors++; $display("FAIL midreset_complete got %0d frames expected 1", dut_fv - fv0); end
      checks++;
      if (last_frame !== 20'h01255) begin errors++; $display("FAIL midreset_frame got %h expected 01255", last_frame); end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL midreset_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
   endtask

   task automatic test_random();
      int fv0, se0, ae0, mfv0, mse0, mae0, mm0, r;
      logic [3:0] a;
      logic [6:0] c;
      do_reset();
      fv0 = dut_fv; se0 = dut_se; ae0 = dut_ae; mm0 = mism_cnt;
      mfv0 = mdl_fv; mse0 = mdl_se; mae0 = mdl_ae;
      for (int k = 0; k < 150; k++) begin
         r = int'($urandom_range(0, 99));
         if (r < 70)      a = slot_an(int'($urandom_range(0, 3)));
         else if (r < 85) a = 4'hf;
         else             a = 4'($urandom);
         if ($urandom_range(0, 99) < 80) c = seg_of(int'($urandom_range(0, 9)));
         else                            c = 7'($urandom);
         hold(a, c, int'($urandom_range(1, 30)));
      end
      hold(4'hf, 7'h7f, int'(T) + 50);
      checks++;
      if (dut_fv - fv0 !== mdl_fv - mfv0) begin
         errors++; $display("FAIL rand_frames got %0d expected %0d", dut_fv - fv0, mdl_fv - mfv0);
      end
      checks++;
      if (dut_se - se0 !== mdl_se - mse0) begin
         errors++; $display("FAIL rand_seg_err got %0d expected %0d", dut_se - se0, mdl_se - mse0);
      end
      checks++;
      if (dut_ae - ae0 !== mdl_ae - mae0) begin
         errors++; $display("FAIL rand_anode_err got %0d expected %0d", dut_ae - ae0, mdl_ae - mae0);
      end
      checks++;
      if (mism_cnt - mm0 !== 0) begin
         errors++; $display("FAIL rand_model cycles %0d dut %h model %h", mism_cnt - mm0, bad_dut, bad_mdl);
      end
      checks++;
      if (dbl_cnt !== 0) begin errors++; $display("FAIL double_pulse got %0d expected 0", dbl_cnt); end
   endtask

   initial begin
      reset_n = 1'b0; an = 4'hf; ca = 7'h7f;
      @(negedge clk);
      test_reset();
      test_clean_scan();
      test_blink();
      test_glitch();
      test_illegal();
      test_simultaneous();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
